// File: rtl/apb_master_pkg.sv
// apb_master_pkg
//   Shared types for the APB requester: default bus widths, the queued
//   command record and the APB phase state encoding.
package apb_master_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;

  // One queued request. Widths follow the package defaults; the top-level
  // ADDR_W/DATA_W parameters are expected to match them.
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_master_cmd_fifo.sv
// apb_cmd_fifo
//   Synchronous command queue of apb_cmd_t between the request port and the
//   APB state machine.
// Ports
//   clk      clock, all state on rising edge
//   Rst      asynchronous active-low reset, empties the queue
//   push     write wr_cmd (ignored while full, even if pop is also high)
//   wr_cmd   command to enqueue
//   pop      discard the head entry (ignored while empty)
//   rd_cmd   head entry, valid whenever empty is low
//   full     no free entry
//   empty    no stored entry
module apb_cmd_fifo
  import apb_master_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     Rst,
  input  logic     push,
  input  apb_cmd_t wr_cmd,
  input  logic     pop,
  output apb_cmd_t rd_cmd,
  output logic     full,
  output logic     empty
);

  localparam int PW = $clog2(DEPTH);

  apb_cmd_t        mem [DEPTH];
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_cmd  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wr_cmd;
  end

endmodule

// File: rtl/apb_master.sv
// apb_master
//   APB requester: accepts valid/ready read/write commands, queues them and
//   replays them as APB SETUP/ACCESS transfers, returning one response pulse
//   per command. Back-to-back commands keep PSel high (2 cycles per transfer).
// Build option
//   APB_MASTER_PREADY_EN  adds PReady wait states with a TIMEOUT_CYC abort and
//                         the rsp_err flag; undefined = fixed 1-cycle ACCESS.
// Ports
//   clk, Rst                      clock, async active-low reset
//   req_valid/req_ready           command handshake
//   req_write/req_addr/req_wdata  command fields
//   rsp_valid/rsp_write/rsp_rdata one-cycle completion response
//   PAddr/PWData/PWrite/PSel/PEnable/PRData  APB requester interface
//   PReady, rsp_err               only with APB_MASTER_PREADY_EN
//
// state  | meaning
// IDLE   | no transfer on the bus, waiting for a queued command
// SETUP  | PSel high, address/data/direction presented
// ACCESS | PEnable high, completes on this edge (or when PReady is high)
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int FIFO_DEPTH  = 4
`ifdef APB_MASTER_PREADY_EN
  ,parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] PAddr,
  output logic [DATA_W-1:0] PWData,
  output logic              PWrite,
  output logic              PSel,
  output logic              PEnable,
  input  logic [DATA_W-1:0] PRData
`ifdef APB_MASTER_PREADY_EN
  ,input  logic             PReady
  ,output logic             rsp_err
`endif
);

  apb_state_t state;
  apb_cmd_t   push_cmd;
  apb_cmd_t   head_cmd;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       ready_en;
  logic       xfer_done;

  // ready_en keeps req_ready low throughout reset and for the rest of the
  // reset-release cycle; it rises on the first clock edge afterwards.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  assign req_ready = ready_en && !fifo_full;
  assign push      = req_valid && req_ready;
  assign push_cmd  = '{write: req_write, addr: req_addr, wdata: req_wdata};

`ifdef APB_MASTER_PREADY_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             xfer_abort;

  // Down-counter of remaining ACCESS wait cycles; reaching zero while
  // PReady is still low ends the transfer with an error response.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      wait_cnt <= '0;
    end else if (state == ST_SETUP) begin
      wait_cnt <= CNT_W'(TIMEOUT_CYC - 1);
    end else if ((state == ST_ACCESS) && !PReady && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign xfer_done  = PReady;
  assign xfer_abort = (state == ST_ACCESS) && !PReady && (wait_cnt == '0);
`else
  assign xfer_done  = 1'b1;
`endif

  // The head command is taken when the bus is free: from IDLE, or at the
  // completion edge of ACCESS so the next SETUP follows without a gap.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || ((state == ST_ACCESS) && xfer_done));

  apb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .Rst    (Rst),
    .push   (push),
    .wr_cmd (push_cmd),
    .pop    (pop),
    .rd_cmd (head_cmd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state     <= ST_IDLE;
      PAddr     <= '0;
      PWData    <= '0;
      PWrite    <= 1'b0;
      PSel      <= 1'b0;
      PEnable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_MASTER_PREADY_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            PAddr  <= head_cmd.addr;
            PWData <= head_cmd.wdata;
            PWrite <= head_cmd.write;
            PSel   <= 1'b1;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PEnable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (xfer_done) begin
            PEnable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= PWrite;
            rsp_rdata <= PWrite ? '0 : PRData;
`ifdef APB_MASTER_PREADY_EN
            rsp_err   <= 1'b0;
`endif
            if (pop) begin
              PAddr  <= head_cmd.addr;
              PWData <= head_cmd.wdata;
              PWrite <= head_cmd.write;
              state  <= ST_SETUP;
            end else begin
              PSel  <= 1'b0;
              state <= ST_IDLE;
            end
          end
`ifdef APB_MASTER_PREADY_EN
          else if (xfer_abort) begin
            PSel      <= 1'b0;
            PEnable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= PWrite;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= ST_IDLE;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
